dec_scan: RTL and testbench

//  Parametrised, registered N-to-NUM_OUT one-hot decoder with two modes:

---
 rtl/dec_pkg.sv | 30 +++
 rtl/dec_onehot.sv | 27 ++
 rtl/dec_scan.sv | 115 +++++++++++
 tb/tb_dec_scan.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared types and helpers for the dec_scan one-hot decoder / scanner.
// The state encoding is fixed so it can be matched against external tooling.
package dec_pkg;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DIRECT = 2'd1;
   localparam logic [1:0] SCAN   = 2'd2;

   typedef enum logic [1:0] {
      StIdle   = IDLE,
      StDirect = DIRECT,
      StScan   = SCAN
   } state_e;

   // Widest decode the helper supports; callers slice the low NUM_OUT bits.
   localparam int unsigned MaxOutW = 8;
   localparam int unsigned MaxOut  = 1 << MaxOutW;

   // One-hot of code over num_out outputs; all-zero when code is out of range.
   function automatic logic [MaxOut-1:0] onehot_f(input logic [31:0] code,
                                                  input int unsigned num_out);
      logic [MaxOut-1:0] r;
      r = '0;
      if (code < 32'(num_out) && code < 32'(MaxOut)) begin
         r[code[MaxOutW-1:0]] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational N -> NUM_OUT active-high one-hot decode with enable and range flag.
// Output polarity is applied by the caller at its output register.
module dec_onehot
   import dec_pkg::*;
#(
   parameter int unsigned N       = 3,
   parameter int unsigned NUM_OUT = 8
) (
   input  logic               en,
   input  logic [N-1:0]       code,
   output logic [NUM_OUT-1:0] dec,
   output logic               in_range
);

   logic [MaxOut-1:0] full;
   logic              unused_full;

   always_comb begin
      full     = onehot_f(32'(code), NUM_OUT);
      in_range = 32'(code) < NUM_OUT;
      dec      = en ? full[NUM_OUT-1:0] : '0;
   end

   // Bits above NUM_OUT are always zero by construction.
   assign unused_full = ^full;

endmodule

// File: rtl/dec_scan.sv
// Registered one-hot decoder with DIRECT (strobed code) and SCAN (timed walk) modes,
// for digit selects, row strobes and chip selects.
module dec_scan
   import dec_pkg::*;
#(
   parameter int unsigned N          = 3,
   parameter int unsigned NUM_OUT    = 8,
   parameter int unsigned DWELL_W    = 8,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic               load,
   input  logic [N-1:0]       code_in,
   input  logic [DWELL_W-1:0] dwell,
   output logic [NUM_OUT-1:0] y,
   output logic [N-1:0]       code_o,
   output logic               sel_v,
   output logic               wrap,
   output logic               err
);

   localparam logic [N:0]         NumOutW  = (N + 1)'(NUM_OUT);
   localparam logic [N-1:0]       LastCode = N'(NUM_OUT - 1);
   localparam logic [NUM_OUT-1:0] Inactive = {NUM_OUT{ACTIVE_LOW}};

   state_e               state_q, state_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic [N-1:0]         code_q, code_d;
   logic                 act_d, wrap_d, err_d;
   logic                 code_ok;
   logic [NUM_OUT-1:0]   dec;
   logic                 in_range;

   assign code_ok = {1'b0, code_in} < NumOutW;

   // Priority: en over mode, and a mode change over load/advance.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      code_d  = code_q;
      act_d   = sel_v;
      wrap_d  = 1'b0;
      err_d   = 1'b0;
      if (!en) begin
         state_d = StIdle;
         act_d   = 1'b0;
      end else if (mode) begin
         act_d = 1'b1;
         if (state_q != StScan) begin
            state_d = StScan;
            code_d  = '0;
         end else if (cnt_q >= dwell) begin
            // >= so that a dwell lowered below the running count advances at once.
            code_d = (code_q == LastCode) ? '0 : code_q + N'(1);
            wrap_d = (code_q == LastCode);
         end else begin
            cnt_d = cnt_q + DWELL_W'(1);
         end
      end else begin
         if (state_q != StDirect) begin
            state_d = StDirect;
            act_d   = 1'b0;
         end else if (load) begin
            if (code_ok) begin
               code_d = code_in;
               act_d  = 1'b1;
            end else begin
               act_d = 1'b0;
               err_d = 1'b1;
            end
         end
      end
   end

   dec_onehot #(
      .N       (N),
      .NUM_OUT (NUM_OUT)
   ) u_dec (
      .en       (act_d),
      .code     (code_d),
      .dec      (dec),
      .in_range (in_range)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         code_q  <= '0;
         y       <= Inactive;
         sel_v   <= 1'b0;
         wrap    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         y       <= dec ^ Inactive;
         sel_v   <= act_d & in_range;
         wrap    <= wrap_d;
         err     <= err_d;
      end
   end

   assign code_o = code_q;

   a_onehot0 : assert property (@(posedge clk) disable iff (rst)
      $countones(y ^ Inactive) <= 1);
   a_sel_v : assert property (@(posedge clk) disable iff (rst)
      sel_v == $onehot(y ^ Inactive));

endmodule

// File: tb/tb_dec_scan.sv
// Randomised plus directed bench for dec_scan: a spec-level model feeds a scoreboard
// queue, a negedge monitor compares both polarity variants of the DUT.
module tb_dec_scan;

   localparam int NumOut = 6;

   typedef struct {
      logic [5:0] y;
      logic [2:0] code;
      logic       sel_v;
      logic       wrap;
      logic       err;
      logic       chk_code;
      int         cyc;
   } exp_t;

   bit         clk;
   logic       rst, en, mode, load;
   logic [2:0] code_in;
   logic [7:0] dwell;

   logic [5:0] y0, y1;
   logic [2:0] code0, code1;
   logic       sel0, sel1, wrap0, wrap1, err0, err1;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   // Model state: which mode we are in, shown code, cycles already spent on it.
   int m_st = 0;
   int m_code = 0;
   int m_held = 0;
   bit m_act = 0;
   bit m_wrap = 0;
   bit m_err = 0;
   bit m_chk = 0;

   always #5 clk = ~clk;

   dec_scan #(.N(3), .NUM_OUT(NumOut), .DWELL_W(8), .ACTIVE_LOW(1'b0)) u_dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .code_in(code_in),
      .dwell(dwell), .y(y0), .code_o(code0), .sel_v(sel0), .wrap(wrap0), .err(err0)
   );

   dec_scan #(.N(3), .NUM_OUT(NumOut), .DWELL_W(8), .ACTIVE_LOW(1'b1)) u_dut_al (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .code_in(code_in),
      .dwell(dwell), .y(y1), .code_o(code1), .sel_v(sel1), .wrap(wrap1), .err(err1)
   );

   task automatic chk(input string nm, input int c, input int got, input int want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, got, want);
      end
   endtask

   function automatic void model_step(bit r, bit e, bit md, bit ld, int ci, int dw);
      m_wrap = 0;
      m_err  = 0;
      if (r) begin
         m_st = 0; m_code = 0; m_held = 0; m_act = 0;
      end else if (!e) begin
         m_st = 0; m_act = 0; m_held = 0;
      end else if (md) begin
         if (m_st != 2) begin
            m_st = 2; m_code = 0; m_held = 0; m_act = 1;
         end else if (m_held >= dw) begin
            m_held = 0;
            m_code = (m_code + 1) % NumOut;
            m_wrap = (m_code == 0);
         end else begin
            m_held++;
         end
      end else begin
         if (m_st != 1) begin
            m_st = 1; m_act = 0;
         end else if (ld) begin
            if (ci < NumOut) begin
               m_code = ci; m_act = 1;
            end else begin
               m_act = 0; m_err = 1;
            end
         end
      end
      m_chk = m_act || r;
   endfunction

   task automatic drive(input bit r, input bit e, input bit md, input bit ld,
                        input int ci, input int dw);
      exp_t x;
      rst = r; en = e; mode = md; load = ld; code_in = 3'(ci); dwell = 8'(dw);
      model_step(r, e, md, ld, ci, dw);
      cyc++;
      x.y        = m_act ? 6'(1 << m_code) : 6'd0;
      x.code     = 3'(m_code);
      x.sel_v    = m_act;
      x.wrap     = m_wrap;
      x.err      = m_err;
      x.chk_code = m_chk;
      x.cyc      = cyc;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         logic [5:0] yinv;
         e = sb.pop_front();
         yinv = ~e.y;
         chk("y", e.cyc, int'(y0), int'(e.y));
         chk("y_active_low", e.cyc, int'(y1), int'(yinv));
         chk("sel_v", e.cyc, int'(sel0), int'(e.sel_v));
         chk("sel_v_al", e.cyc, int'(sel1), int'(e.sel_v));
         chk("wrap", e.cyc, int'(wrap0), int'(e.wrap));
         chk("wrap_al", e.cyc, int'(wrap1), int'(e.wrap));
         chk("err", e.cyc, int'(err0), int'(e.err));
         chk("err_al", e.cyc, int'(err1), int'(e.err));
         chk("y_at_most_one", e.cyc, int'($countones(y0) <= 1), 1);
         if (e.chk_code) begin
            chk("code_o", e.cyc, int'(code0), int'(e.code));
            chk("code_o_al", e.cyc, int'(code1), int'(e.code));
         end
      end
   end

   initial begin
      bit md;
      int dw;
      // Reset, then rst held with en=1.
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 1, 4, 0);
      drive(1, 1, 1, 1, 4, 0);
      // DIRECT: enter, load 4, hold, load 7 (error), load 5, load 6 (error).
      drive(0, 1, 0, 0, 0, 0);
      drive(0, 1, 0, 1, 4, 0);
      repeat (3) drive(0, 1, 0, 0, 1, 0);
      drive(0, 1, 0, 1, 7, 0);
      drive(0, 1, 0, 0, 0, 0);
      drive(0, 1, 0, 1, 5, 0);
      drive(0, 1, 0, 1, 6, 0);
      drive(0, 1, 0, 1, 0, 0);
      // SCAN dwell=2 across two full cycles of codes.
      repeat (40) drive(0, 1, 1, 0, 0, 2);
      // dwell=0, then lower dwell 5 -> 1 at count 3.
      repeat (10) drive(0, 1, 1, 0, 0, 0);
      repeat (3) drive(0, 1, 1, 0, 0, 5);
      drive(0, 1, 1, 0, 0, 1);
      repeat (4) drive(0, 1, 1, 0, 0, 1);
      // Mid-scan at code 3: en=0 then en=1 restarts at 0.
      for (int i = 0; i < 100 && !(m_code == 3 && m_held == 0); i++) drive(0, 1, 1, 0, 0, 2);
      drive(0, 0, 1, 0, 0, 2);
      repeat (5) drive(0, 1, 1, 0, 0, 2);
      // rst on the cycle that would wrap: no wrap pulse.
      for (int i = 0; i < 100 && !(m_code == NumOut - 1 && m_held == 2); i++)
         drive(0, 1, 1, 0, 0, 2);
      drive(1, 1, 1, 0, 0, 2);
      drive(0, 1, 1, 0, 0, 2);
      drive(0, 1, 1, 0, 0, 2);
      // DIRECT load 2, then mode->SCAN with load in the same cycle.
      drive(0, 1, 0, 0, 0, 0);
      drive(0, 1, 0, 1, 2, 0);
      drive(0, 1, 1, 1, 2, 0);
      drive(0, 1, 1, 0, 0, 0);
      // Random traffic.
      md = 1'b0;
      dw = 1;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 14) == 0) md = ~md;
         if ($urandom_range(0, 9) == 0) dw = $urandom_range(0, 3);
         drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) != 0), md,
               ($urandom_range(0, 2) == 0), $urandom_range(0, 7), dw);
      end
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      #1;
      chk("scoreboard_drained", cyc, sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
